// File: rtl/ssp_tx_pkg.sv
// Shared types and defaults for the SSP frame transmitter.
//   state_t         : transmitter FSM state encoding
//   DATA_W          : transmitted word width (bits)
//   CLK_DIV_DEF     : default serial half-period in clk cycles
//   FIFO_DEPTH_DEF  : default transmit FIFO depth (words)
package ssp_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned CLK_DIV_DEF    = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/ssp_tx_fifo.sv
// Synchronous transmit FIFO with registered status flags.
//   clk, rst  : clock, synchronous active-high reset (flushes contents)
//   wr_data   : word to store; push stores it when space exists or a pop
//               happens at the same edge
//   pop       : remove head word (ignored when empty)
//   rd_data   : current head word (valid while not empty)
//   full, empty, txintr : flags for the count after this edge's push/pop
//   ovf       : one-cycle pulse when a push was dropped
module ssp_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          txintr,
  output logic          ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_n;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full FIFO still succeeds when the head leaves at the same edge.
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      txintr <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_n;
      full   <= (count_n == FULL_CNT);
      empty  <= (count_n == '0);
      txintr <= (count_n <= HALF_CNT);
      ovf    <= push && !do_push;
    end
  end

endmodule

// File: rtl/ssp_frame_tx.sv
// SSP (TI synchronous serial format) frame transmitter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   dat_i, we_i  : word to queue and its write strobe
//   full_o, empty_o, txintr_o, ovf_o : FIFO status / dropped-write pulse
//   busy_o       : frame in progress
//   sspclk_o, sspfss_o, ssptxd_o, sspoe_b_o : serial port pins
// Each frame is one SYNC bit period (frame sync high) followed by eight
// data bit periods, MSB first. A bit period is CLK_DIV cycles of sspclk
// high then CLK_DIV cycles low; data changes only at the rising edge.
module ssp_frame_tx
  import ssp_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              we_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              txintr_o,
  output logic              busy_o,
  output logic              sspclk_o,
  output logic              sspfss_o,
  output logic              ssptxd_o,
  output logic              sspoe_b_o
);

  localparam int unsigned   DIVW    = $clog2(2 * CLK_DIV);
  localparam logic [DIVW-1:0] DIV_MAX = DIVW'(2 * CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV);

  state_t            state, state_n;
  logic [DIVW-1:0]   div_cnt, div_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [DATA_W-1:0] sh_q, sh_n;
  logic              txd_n, fss_n;
  logic              pop;
  logic              period_end;
  logic [DATA_W-1:0] head;

  ssp_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_W)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_data (dat_i),
    .push    (we_i),
    .pop     (pop),
    .rd_data (head),
    .full    (full_o),
    .empty   (empty_o),
    .txintr  (txintr_o),
    .ovf     (ovf_o)
  );

  assign period_end = (div_cnt == DIV_MAX);

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    sh_n    = sh_q;
    txd_n   = ssptxd_o;
    fss_n   = sspfss_o;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        bit_n = '0;
        fss_n = 1'b0;
        txd_n = 1'b0;
        // empty_o is registered, so a word written at this same edge is
        // only seen (and popped) at the next one.
        if (!empty_o) begin
          pop     = 1'b1;
          sh_n    = head;
          state_n = SYNC;
          fss_n   = 1'b1;
        end
      end
      SYNC: begin
        div_n = period_end ? '0 : div_cnt + 1'b1;
        if (period_end) begin
          state_n = SHIFT;
          bit_n   = 3'd7;
          fss_n   = 1'b0;
          txd_n   = sh_q[DATA_W-1];
          sh_n    = {sh_q[DATA_W-2:0], 1'b0};
        end
      end
      SHIFT: begin
        div_n = period_end ? '0 : div_cnt + 1'b1;
        if (period_end) begin
          if (bit_cnt == 3'd0) begin
            if (!empty_o) begin
              pop     = 1'b1;
              sh_n    = head;
              state_n = SYNC;
              fss_n   = 1'b1;
              txd_n   = 1'b0;
            end else begin
              state_n = IDLE;
              fss_n   = 1'b0;
              txd_n   = 1'b0;
            end
          end else begin
            bit_n = bit_cnt - 3'd1;
            txd_n = sh_q[DATA_W-1];
            sh_n  = {sh_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
      end
    endcase
  end

  // Pin outputs are registered from next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sh_q      <= '0;
      sspclk_o  <= 1'b0;
      sspfss_o  <= 1'b0;
      ssptxd_o  <= 1'b0;
      sspoe_b_o <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= (state_n == IDLE) ? '0 : div_n;
      bit_cnt   <= bit_n;
      sh_q      <= sh_n;
      sspclk_o  <= (state_n != IDLE) && (div_n < DIV_HALF);
      sspfss_o  <= fss_n;
      ssptxd_o  <= txd_n;
      sspoe_b_o <= (state_n == IDLE);
      busy_o    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_ssp_frame_tx.sv
module tb_ssp_frame_tx;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] dat_i;
  logic       we_i;
  logic       full_o, empty_o, ovf_o, txintr_o, busy_o;
  logic       sspclk_o, sspfss_o, ssptxd_o, sspoe_b_o;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb [$];

  localparam logic [8:0] RST_VEC = 9'b0_0_0_1_0_0_0_1_1;

  ssp_frame_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .we_i(we_i),
    .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .txintr_o(txintr_o),
    .busy_o(busy_o), .sspclk_o(sspclk_o), .sspfss_o(sspfss_o),
    .ssptxd_o(ssptxd_o), .sspoe_b_o(sspoe_b_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [8:0] outs();
    return {sspclk_o, sspfss_o, ssptxd_o, sspoe_b_o, busy_o, ovf_o, full_o, empty_o, txintr_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write one word at the next rising edge; returns #1 after that edge.
  task automatic wr(input logic [7:0] d);
    we_i = 1'b1; dat_i = d;
    @(posedge clk_i); #1;
    we_i = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy_o && k < lim) begin
      @(posedge clk_i); #1; k++;
    end
    check("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  // Monitor: reassemble frames from pins at sspclk falling edges.
  logic       prev_clk = 1'b0;
  logic       in_frame = 1'b0;
  logic [7:0] word;
  int         nb;
  always @(negedge clk_i) begin
    if (rst_i) begin
      in_frame = 1'b0;
      prev_clk = 1'b0;
    end else begin
      if (prev_clk && !sspclk_o) begin
        if (sspfss_o) begin
          in_frame = 1'b1; nb = 0;
        end else if (in_frame) begin
          check("oe_b_in_frame", {31'd0, sspoe_b_o}, 32'd0);
          word = {word[6:0], ssptxd_o};
          nb++;
          if (nb == 8) begin
            in_frame = 1'b0;
            if (sb.size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL unexpected_frame: got %0h expected none", word);
            end else begin
              check("frame_word", {24'd0, word}, {24'd0, sb.pop_front()});
            end
          end
        end
      end
      prev_clk = sspclk_o;
    end
  end

  initial begin
    int n;
    rst_i = 1'b1; we_i = 1'b0; dat_i = '0;
    repeat (3) @(posedge clk_i); #1;
    check("reset_outputs", {23'd0, outs()}, {23'd0, RST_VEC});
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Single frame 0xA5, latency and sync width
    sb.push_back(8'hA5);
    wr(8'hA5);
    check("e0_fss", {30'd0, sspfss_o, sspclk_o}, 32'd0);
    check("e0_empty", {31'd0, empty_o}, 32'd0);
    @(posedge clk_i); #1;
    check("e1_fss_clk_busy", {29'd0, sspfss_o, sspclk_o, busy_o}, 32'd7);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #1;
      if (sspfss_o) n++; else break;
    end
    check("fss_width", n, 8);
    wait_idle(200);
    check("idle_oe_b", {31'd0, sspoe_b_o}, 32'd1);
    check("idle_outputs", {23'd0, outs()}, {23'd0, RST_VEC});

    // Back-to-back frames: 144 busy cycles
    sb.push_back(8'h3C); sb.push_back(8'hC3);
    wr(8'h3C);
    wr(8'hC3);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_i); #1;
      if (busy_o) n++; else break;
    end
    check("b2b_busy_cycles", n, 144);

    // Overflow while stalled by a frame in progress
    sb.push_back(8'h81);
    wr(8'h81);
    @(posedge clk_i); #1;
    begin
      logic [7:0] w [6];
      logic [5:0] exp_ovf, exp_full, exp_txi;
      w[0] = 8'h12; w[1] = 8'h34; w[2] = 8'h56; w[3] = 8'h78; w[4] = 8'h9A; w[5] = 8'hBC;
      exp_ovf  = 6'b110000;
      exp_full = 6'b111000;
      exp_txi  = 6'b000011;
      for (int i = 0; i < 6; i++) begin
        if (i < 4) sb.push_back(w[i]);
        wr(w[i]);
        check("ovf_seq",    {31'd0, ovf_o},    {31'd0, exp_ovf[i]});
        check("full_seq",   {31'd0, full_o},   {31'd0, exp_full[i]});
        check("txintr_seq", {31'd0, txintr_o}, {31'd0, exp_txi[i]});
      end
    end
    @(posedge clk_i); #1;
    check("ovf_clear", {31'd0, ovf_o}, 32'd0);
    wait_idle(600);

    // Full FIFO, write coincides with frame-end pop
    sb.push_back(8'h11);
    wr(8'h11);                        // edge E
    sb.push_back(8'h22); wr(8'h22);   // E+1
    sb.push_back(8'h33); wr(8'h33);
    sb.push_back(8'h44); wr(8'h44);
    sb.push_back(8'h55); wr(8'h55);   // E+4
    repeat (68) @(posedge clk_i);     // E+72
    #1;
    check("pre_pop_full", {31'd0, full_o}, 32'd1);
    sb.push_back(8'h66); wr(8'h66);   // E+73: pop and push together
    check("pop_push_full", {31'd0, full_o}, 32'd1);
    check("pop_push_ovf", {31'd0, ovf_o}, 32'd0);
    wait_idle(600);

    // Reset aborts a frame during bit 3 of 0xFF
    wr(8'hFF);                        // edge E
    repeat (43) @(posedge clk_i);     // E+43
    #1;
    check("pre_abort_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;             // E+44 is within bit 3
    check("abort_outputs", {23'd0, outs()}, {23'd0, RST_VEC});
    rst_i = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #1;
      if (sspfss_o || busy_o) n++;
    end
    check("no_frame_after_abort", n, 0);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
